// File: rtl/ppu_vblank_nmi_if.sv
`default_nettype none
// ============================================================================
// Module      : ppu_vblank_nmi_if
// Description : Signal bundle between the CPU/bus side and the PPU vblank/NMI
//               timing stage.
//               master : drives dot_en, nmi_enable, status_read,
//                        rendering_enabled; observes position, flags and nmi_n.
//               slave  : the timing stage itself (ppu_vblank_nmi).
// Revision    : 1.0 - initial release
// ============================================================================
interface ppu_vblank_nmi_if;
    logic       dot_en;             // PPU dot tick
    logic       nmi_enable;         // PPUCTRL bit 7
    logic       status_read;        // one-clk pulse, CPU read of $2002
    logic       rendering_enabled;  // PPUMASK bg|sprite enable
    logic [8:0] dot;                // current dot
    logic [8:0] scanline;           // current scanline
    logic       vblank_flag;        // $2002 bit 7
    logic       vblank_status;      // value returned by a $2002 read
    logic       nmi_n;              // active-low NMI request
    logic       frame_odd;          // odd-frame parity
    logic       frame_start;        // pulse on wrap to (0,0)

    modport master (
        output dot_en, nmi_enable, status_read, rendering_enabled,
        input  dot, scanline, vblank_flag, vblank_status, nmi_n,
               frame_odd, frame_start
    );

    modport slave (
        input  dot_en, nmi_enable, status_read, rendering_enabled,
        output dot, scanline, vblank_flag, vblank_status, nmi_n,
               frame_odd, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/ppu_vblank_nmi.sv
`default_nettype none
// ============================================================================
// Module      : ppu_vblank_nmi
// Description : PPU timing stage producing the /NMI line for the CPU's NMI
//               falling-edge detector. Runs the dot/scanline counters, sets
//               and clears the vblank flag, applies PPUCTRL.7 gating and the
//               $2002-read race suppression, and registers nmi_n.
// Ports       : clk  - system clock (posedge)
//               rst  - asynchronous active-high reset
//               bus  - ppu_vblank_nmi_if.slave (inputs dot_en, nmi_enable,
//                      status_read, rendering_enabled; outputs dot, scanline,
//                      vblank_flag, vblank_status, nmi_n, frame_odd,
//                      frame_start)
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_vblank_nmi #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241,
    parameter int PRERENDER_LINE  = 261
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ppu_vblank_nmi_if.slave  bus
);

    localparam logic [8:0] c_DOT_LAST       = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_DOT_SKIP       = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] c_LINE_LAST      = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] c_VBLANK_LINE    = 9'(VBLANK_LINE);
    localparam logic [8:0] c_PRERENDER_LINE = 9'(PRERENDER_LINE);

    logic [8:0] dot_q, dot_d;
    logic [8:0] scanline_q, scanline_d;
    logic       vblank_flag_q, vblank_flag_d;
    logic       nmi_n_q, nmi_n_d;
    logic       frame_odd_q, frame_odd_d;
    logic       frame_start_q, frame_start_d;

    logic       wrap;
    logic       set_event;
    logic       clear_event;

    // ------------------------------------------------------------------
    // Position counters, frame parity and frame_start pulse
    // ------------------------------------------------------------------
    always_comb begin
        dot_d         = dot_q;
        scanline_d    = scanline_q;
        frame_odd_d   = frame_odd_q;
        frame_start_d = 1'b0;
        wrap          = 1'b0;

        if (bus.dot_en) begin
            // Odd frames with rendering on drop the last dot of the
            // pre-render line; rendering_enabled matters only on this tick.
            if (scanline_q == c_PRERENDER_LINE && dot_q == c_DOT_SKIP &&
                frame_odd_q && bus.rendering_enabled) begin
                wrap = 1'b1;
            end else if (dot_q == c_DOT_LAST) begin
                if (scanline_q == c_LINE_LAST) begin
                    wrap = 1'b1;
                end else begin
                    dot_d      = 9'd0;
                    scanline_d = scanline_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end

        if (wrap) begin
            dot_d         = 9'd0;
            scanline_d    = 9'd0;
            frame_odd_d   = ~frame_odd_q;
            frame_start_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // vblank flag: a $2002 read wins over a set on the same edge, so a
    // read landing exactly on the set tick loses that frame's vblank.
    // ------------------------------------------------------------------
    assign set_event   = bus.dot_en && (scanline_q == c_VBLANK_LINE)    && (dot_q == 9'd0);
    assign clear_event = bus.dot_en && (scanline_q == c_PRERENDER_LINE) && (dot_q == 9'd0);

    always_comb begin
        vblank_flag_d = vblank_flag_q;
        if (bus.status_read) begin
            vblank_flag_d = 1'b0;
        end else if (set_event) begin
            vblank_flag_d = 1'b1;
        end else if (clear_event) begin
            vblank_flag_d = 1'b0;
        end
    end

    // nmi_n follows the pre-edge flag and the live enable, one clk behind.
    always_comb begin
        nmi_n_d = ~(vblank_flag_q & bus.nmi_enable);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_q         <= 9'd0;
            scanline_q    <= 9'd0;
            vblank_flag_q <= 1'b0;
            nmi_n_q       <= 1'b1;
            frame_odd_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            dot_q         <= dot_d;
            scanline_q    <= scanline_d;
            vblank_flag_q <= vblank_flag_d;
            nmi_n_q       <= nmi_n_d;
            frame_odd_q   <= frame_odd_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.dot           = dot_q;
    assign bus.scanline      = scanline_q;
    assign bus.vblank_flag   = vblank_flag_q;
    // A read sees the flag as it stood before the read's clearing edge.
    assign bus.vblank_status = vblank_flag_q;
    assign bus.nmi_n         = nmi_n_q;
    assign bus.frame_odd     = frame_odd_q;
    assign bus.frame_start   = frame_start_q;

endmodule
`default_nettype wire
